dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single data memory (dmem) between two requesters: the core MEM stage and an external port (loader/debug).
- Core gets priority by default; a starvation counter guarantees the external port gets service.
- Core reads keep the current combinational-read timing. External reads return registered data one cycle after grant.
- Sits between the core's MEM-stage signals and the dmem instance. Its stall output freezes the core pipeline.

Parameters:
- DWIDTH, 32, data width.
- AWIDTH, 32, address width.
- STARVE_LIMIT, 4, consecutive denied cycles of a pending external request before the external port takes priority. Must be at least 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- core_req  input  1  core MEM stage needs dmem this cycle (load or store).
- core_we  input  1  core store.
- core_addr  input  AWIDTH  core address.
- core_wdata  input  DWIDTH  core store data.
- core_rdata  output  DWIDTH  load data to core; valid when core_req=1 and core_stall=0.
- core_stall  output  1  core denied this cycle; core must hold its MEM stage.
- ext_req  input  1  external request; held with stable fields until ext_gnt.
- ext_we  input  1  external write.
- ext_addr  input  AWIDTH  external address.
- ext_wdata  input  DWIDTH  external write data.
- ext_gnt  output  1  one-cycle pulse: external access performed this cycle.
- ext_rvalid  output  1  one-cycle pulse, the cycle after a read grant.
- ext_rdata  output  DWIDTH  registered external read data.
- mem_we  output  1  to dmem write enable.
- mem_addr  output  AWIDTH  to dmem address.
- mem_wdata  output  DWIDTH  to dmem write data.
- mem_rdata  input  DWIDTH  from dmem; combinational read.

Behaviour:
- FSM states: CORE_PRI, EXT_PRI. Starvation counter starve_cnt has width clog2(STARVE_LIMIT+1).
- Owner selection (combinational):
  - CORE_PRI: core if core_req, else ext if ext_req, else none.
  - EXT_PRI: ext if ext_req, else core if core_req, else none.
- Memory side:
  - Owner core: mem_addr/mem_wdata = core fields; mem_we = core_we.
  - Owner ext: mem_addr/mem_wdata = ext fields; mem_we = ext_we.
  - Owner none: mem_we=0, mem_addr=0, mem_wdata=0.
- core_stall = core_req and owner is ext.
- core_rdata = mem_rdata, unconditionally.
- ext_gnt = owner is ext.
- Denied cycle: ext_req=1 and owner is core.
  - CORE_PRI, denied, starve_cnt < STARVE_LIMIT-1: increment starve_cnt.
  - CORE_PRI, denied, starve_cnt = STARVE_LIMIT-1: go to EXT_PRI, starve_cnt kept.
- Any ext grant (either state): starve_cnt <= 0, state <= CORE_PRI.
- EXT_PRI with ext_req=0 (protocol violation): state <= CORE_PRI, starve_cnt <= 0.
- External read grant (ext_gnt and not ext_we):
  - Next edge: ext_rdata <= mem_rdata, ext_rvalid <= 1.
  - Otherwise ext_rvalid <= 0 and ext_rdata holds.
- Writes complete at the grant edge; no rvalid for writes.
- Back-to-back external requests are legal; each gets its own gnt and rvalid.
- Maximum external wait after ext_req rises: STARVE_LIMIT denied cycles, then grant.
- Core wait when stalled: exactly 1 cycle per external grant.
- Reset (rst=0, asynchronous):
  - State CORE_PRI, starve_cnt=0, ext_rvalid=0, ext_rdata=0.
  - Combinational outputs gated while rst=0: mem_we=0, ext_gnt=0, core_stall=0.
- Reset mid-read: rvalid for an in-flight read is dropped.
- No state change occurs without a clock edge except reset.

Decomposition:
- Shared package: arbiter state encodings (CORE_PRI=1'b0, EXT_PRI=1'b1) and owner encodings (OWN_NONE, OWN_CORE, OWN_EXT).
- Core pipeline stall, DWIDTH and the dmem interface stay as in the core.
- No sub-module; the owner mux, FSM/counter and read-return register fit in one module.

Test Plan:
- Reset: hold rst=0 with both requests asserted -> mem_we=0, ext_gnt=0, core_stall=0, ext_rvalid=0. Release rst -> state CORE_PRI.
- Ext only: ext read at 0x10, dmem[0x10]=0xDEADBEEF, core idle -> ext_gnt in the same cycle; next cycle ext_rvalid=1 and ext_rdata=0xDEADBEEF.
- Core priority: core_req and ext write held together for 3 cycles (STARVE_LIMIT=4) -> core served each cycle, core_stall=0, starve_cnt reaches 3.
- Starvation: core_req held continuously, ext write 0x55 to 0x20 -> denied 4 cycles, granted on cycle 5 with core_stall=1 that cycle, dmem[0x20]=0x55, starve_cnt=0 afterwards.
- Core store/load during ext traffic: core store 0x1234 to 0x8, then load 0x8 with no ext request -> core_rdata=0x1234 with no stall.
- Reset mid-read: ext read granted, rst=0 asserted before the next edge -> ext_rvalid stays 0 and ext_rdata=0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the dmem arbiter: FSM state constants and access-owner codes.
package dmem_arbiter_pkg;

  localparam logic CORE_PRI = 1'b0;
  localparam logic EXT_PRI  = 1'b1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares dmem between the core MEM stage and an external port; core reads are combinational,
// external reads return one cycle after grant. Core is stalled only on cycles the external port owns dmem.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [AWIDTH-1:0] core_addr,
  input  logic [DWIDTH-1:0] core_wdata,
  output logic [DWIDTH-1:0] core_rdata,
  output logic              core_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [AWIDTH-1:0] ext_addr,
  input  logic [DWIDTH-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DWIDTH-1:0] ext_rdata,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT - 1);

  logic           state;
  logic [SCW-1:0] starve_cnt;
  owner_e         owner;

  // Owner is forced to none while reset is asserted so nothing reaches dmem or the core.
  always_comb begin
    owner = OWN_NONE;
    if (rst) begin
      if (state == EXT_PRI) begin
        if (ext_req)       owner = OWN_EXT;
        else if (core_req) owner = OWN_CORE;
      end else begin
        if (core_req)      owner = OWN_CORE;
        else if (ext_req)  owner = OWN_EXT;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (owner)
      OWN_CORE: begin
        mem_we    = core_we;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
      end
      OWN_EXT: begin
        mem_we    = ext_we;
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
      end
      default: ;
    endcase
  end

  assign ext_gnt    = (owner == OWN_EXT);
  assign core_stall = core_req && (owner == OWN_EXT);
  assign core_rdata = mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= CORE_PRI;
      starve_cnt <= '0;
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      if (owner == OWN_EXT) begin
        state      <= CORE_PRI;
        starve_cnt <= '0;
      end else if (state == EXT_PRI) begin
        // Only reachable if ext_req dropped before its grant.
        state      <= CORE_PRI;
        starve_cnt <= '0;
      end else if (ext_req && owner == OWN_CORE) begin
        if (starve_cnt == STARVE_MAX) state <= EXT_PRI;
        else                          starve_cnt <= starve_cnt + 1'b1;
      end

      ext_rvalid <= ext_gnt && !ext_we;
      if (ext_gnt && !ext_we) ext_rdata <= mem_rdata;
    end
  end

endmodule
